io_port_bridge: RTL and testbench
=================================

# io_port_bridge

External-side peripheral for the CPU's port I/O: it is the device the CPU's output-port writes land on and its input-port reads come from. CPU byte writes are buffered in a TX FIFO and drained to an external consumer over a valid/ready handshake. An external producer fills an RX FIFO that the CPU reads through its input-port mux, together with a status byte. It sits outside the CPU core, between the core's I/O pins and the board-level devices.

## Interface
- WIDTH, 8, data byte width
- DEPTH, 4, entries per FIFO; legal values 2 or 4 so counts fit 3 bits
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- we_out  in  1  CPU output-write strobe
- port_sel  in  2  CPU output port number (instruction bits [1:0])
- wdata  in  WIDTH  CPU output data (output-mux value)
- rd_en  in  1  CPU read strobe for the data input; pops RX on the clock edge
- status  out  8  to CPU input 0
- rdata  out  WIDTH  to CPU input 1; RX head, first-word fall-through
- tx_data  out  WIDTH  TX head
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  external consumer accepts
- rx_data  in  WIDTH  external producer byte
- rx_valid  in  1  producer offers a byte
- rx_ready  out  1  RX FIFO not full

## Operation
- Port map: port_sel=0 is the TX data push. port_sel=1 is the control write. 2 and 3 are ignored (no state change).
- Control bits (self-clearing, act on the write edge):
  - [0] flush TX
  - [1] flush RX
  - [2] clear tx_ovf
  - [3] clear rx_unf
  - [7:4] ignored
- status:
  - [0] RX non-empty
  - [1] TX full
  - [2] TX empty
  - [3] tx_ovf (sticky)
  - [4] rx_unf (sticky)
  - [7:5] RX count 0..DEPTH
- TX push:
  - we_out & port_sel==0 & not full → write wdata.
  - If TX is full, the byte is dropped and tx_ovf is set, unless a pop happens the same edge. In that case the push is accepted and tx_ovf is not set.
- TX pop: on tx_valid & tx_ready.
- RX push: on rx_valid & rx_ready. rx_ready = !rx_full, computed from the registered count only. A same-cycle rd_en on a full RX therefore does not admit a push.
- RX pop: on rd_en & non-empty. rd_en with RX empty → no pop, rx_unf set.
- rdata and tx_data drive 0 when their FIFO is empty.
- Flush vs. same-edge push/pop: flush wins. The FIFO is empty after the edge and the concurrent push is discarded. An RX flush with a same-edge rd_en on empty still sets rx_unf.
- Count arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is 3 bits, with simultaneous push+pop leaving the count unchanged.

## Timing
- Reset values: FIFOs empty; tx_ovf=0, rx_unf=0; tx_valid=0, tx_data=0, rdata=0, rx_ready=1; status=8'b0000_0100.
- Reset asserted mid-transfer: contents are lost immediately and asynchronously, and outputs go to their reset values without waiting for clk.
- CPU write → tx_valid/tx_data visible the cycle after the write edge (1-cycle latency).
- RX push → rdata/status visible the cycle after the push edge.
- rdata is combinational from registers, so a single-cycle CPU reads it in the same cycle rd_en is high. The next head appears after that edge.
- Throughput: one TX push and one TX pop per cycle, one RX push and one RX pop per cycle, all concurrently.
- tx_valid never depends combinationally on tx_ready. rx_ready never depends combinationally on rx_valid or rd_en.

## Structure
- Package io_port_pkg holds:
  - port_sel codes (PORT_TXDATA=0, PORT_CTRL=1)
  - control bit indices
  - status bit indices and count field position
- Sub-module fifo_sync (WIDTH, DEPTH; push, pop, flush, head, count, full, empty) is instantiated twice, once for TX and once for RX.
- The top level holds the port decode, the sticky flags, and status assembly.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 to port 0 with tx_ready=0 → tx_valid=1, tx_data=0x11, status[2]=0. Raise tx_ready → 0x11, 0x22, 0x33 on consecutive cycles, then tx_valid=0 and status[2]=1.
- Five writes to port 0 with tx_ready=0 → status[1]=1 after the fourth, status[3]=1 after the fifth, and 0x55 is never emitted. Write control 0x04 → status[3]=0.
- Push 0xA0..0xA3 with rx_valid=1 → rx_ready=0 and status[7:5]=4. rd_en four times → rdata 0xA0..0xA3 in order. A fifth rd_en → status[4]=1 and rdata=0.
- TX full, with we_out on port 0 and tx_ready=1 on the same edge → push accepted, count stays 4, tx_ovf remains 0.
- RX holding 2 bytes, then control write 0x03 while rx_valid=1 → both FIFOs empty the next cycle and the offered byte is discarded.
- Drop reset low mid-stream while tx_valid=1 → tx_valid=0, rx_ready=1, and status=0x04 without a clock edge.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared constants for the CPU port-I/O bridge: port codes, control bits and
// status byte layout.
package io_port_pkg;

  typedef enum logic [1:0] {
    PORT_TXDATA = 2'd0,
    PORT_CTRL   = 2'd1,
    PORT_RSVD2  = 2'd2,
    PORT_RSVD3  = 2'd3
  } port_e;

  localparam int CTRL_FLUSH_TX  = 0;
  localparam int CTRL_FLUSH_RX  = 1;
  localparam int CTRL_CLR_TXOVF = 2;
  localparam int CTRL_CLR_RXUNF = 3;

  localparam int ST_RX_NEMPTY = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_OVF    = 3;
  localparam int ST_RX_UNF    = 4;
  localparam int ST_CNT_LSB   = 5;
  localparam int ST_CNT_W     = 3;

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with first-word fall-through head and flush.
// Callers qualify push/pop; flush overrides both on the same edge.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [2:0]    CNT_MAX = 3'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [2:0]       r_count;

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PTR_ONE;
      if (pop)  r_rptr <= r_rptr + PTR_ONE;
      r_count <= r_count + {2'b00, push} - {2'b00, pop};
    end
  end

  assign count = r_count;
  assign full  = (r_count == CNT_MAX);
  assign empty = (r_count == 3'd0);
  assign head  = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/io_port_bridge.sv
// CPU port-I/O bridge: buffers CPU output writes to an external consumer and
// collects bytes from an external producer for the CPU's input ports.
module io_port_bridge
  import io_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_out,
  input  logic [1:0]       port_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [7:0]       status,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready
);

  logic       w_tx_wr, w_ctrl_wr;
  logic       w_tx_push, w_tx_pop, w_tx_drop, w_tx_flush;
  logic       w_rx_push, w_rx_pop, w_rx_unf_evt, w_rx_flush;
  logic       w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [2:0] w_tx_count, w_rx_count;
  logic       r_tx_ovf, r_rx_unf;

  assign w_tx_wr   = we_out && (port_sel == PORT_TXDATA);
  assign w_ctrl_wr = we_out && (port_sel == PORT_CTRL);

  // A full TX still takes the write when the consumer drains a slot this edge.
  assign w_tx_pop   = !w_tx_empty && tx_ready;
  assign w_tx_push  = w_tx_wr && (!w_tx_full || w_tx_pop);
  assign w_tx_drop  = w_tx_wr && w_tx_full && !w_tx_pop;
  assign w_tx_flush = w_ctrl_wr && wdata[CTRL_FLUSH_TX];

  assign w_rx_push    = rx_valid && !w_rx_full;
  assign w_rx_pop     = rd_en && !w_rx_empty;
  assign w_rx_unf_evt = rd_en && w_rx_empty;
  assign w_rx_flush   = w_ctrl_wr && wdata[CTRL_FLUSH_RX];

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .flush (w_tx_flush),
    .din   (wdata),
    .head  (tx_data),
    .count (w_tx_count),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .flush (w_rx_flush),
    .din   (rx_data),
    .head  (rdata),
    .count (w_rx_count),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  // Set beats clear so an error on the clearing edge is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      if (w_tx_drop)
        r_tx_ovf <= 1'b1;
      else if (w_ctrl_wr && wdata[CTRL_CLR_TXOVF])
        r_tx_ovf <= 1'b0;
      if (w_rx_unf_evt)
        r_rx_unf <= 1'b1;
      else if (w_ctrl_wr && wdata[CTRL_CLR_RXUNF])
        r_rx_unf <= 1'b0;
    end
  end

  always_comb begin
    status                                 = '0;
    status[ST_RX_NEMPTY]                   = !w_rx_empty;
    status[ST_TX_FULL]                     = w_tx_full;
    status[ST_TX_EMPTY]                    = w_tx_empty;
    status[ST_TX_OVF]                      = r_tx_ovf;
    status[ST_RX_UNF]                      = r_rx_unf;
    status[ST_CNT_LSB +: ST_CNT_W]         = w_rx_count;
  end

  assign tx_valid = !w_tx_empty;
  assign rx_ready = !w_rx_full;

  logic w_unused;
  assign w_unused = ^w_tx_count;

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed, table-driven bench for io_port_bridge with hand-computed
// expectations plus hand-written reset sequences.
module tb_io_port_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       we_out;
  logic [1:0] port_sel;
  logic [7:0] wdata;
  logic       rd_en;
  logic [7:0] status;
  logic [7:0] rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  io_port_bridge #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .we_out   (we_out),
    .port_sel (port_sel),
    .wdata    (wdata),
    .rd_en    (rd_en),
    .status   (status),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] sel;
    logic [7:0] wd;
    logic       rd;
    logic       txr;
    logic [7:0] rxd;
    logic       rxv;
    logic [7:0] e_st;
    logic       e_txv;
    logic [7:0] e_txd;
    logic [7:0] e_rdt;
    logic       e_rxr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [1:0] sel, input logic [7:0] wd,
                     input logic rd, input logic txr, input logic [7:0] rxd, input logic rxv,
                     input logic [7:0] e_st, input logic e_txv, input logic [7:0] e_txd,
                     input logic [7:0] e_rdt, input logic e_rxr);
    vec_t v;
    v.we = we; v.sel = sel; v.wd = wd; v.rd = rd; v.txr = txr; v.rxd = rxd; v.rxv = rxv;
    v.e_st = e_st; v.e_txv = e_txv; v.e_txd = e_txd; v.e_rdt = e_rdt; v.e_rxr = e_rxr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 0x%02h expected 0x%02h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    we_out = 1'b0; port_sel = 2'd0; wdata = 8'h00; rd_en = 1'b0;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();

    //     we sel wd     rd txr rxd    rxv | status txv txd    rdata  rxr
    // TX ordering and drain
    add(1, 0, 8'h11, 0, 0, 8'h00, 0,  8'h00, 1, 8'h11, 8'h00, 1);
    add(1, 0, 8'h22, 0, 0, 8'h00, 0,  8'h00, 1, 8'h11, 8'h00, 1);
    add(1, 0, 8'h33, 0, 0, 8'h00, 0,  8'h00, 1, 8'h11, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h00, 1, 8'h22, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h00, 1, 8'h33, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h04, 0, 8'h00, 8'h00, 1);
    // TX overflow, clear, full push+pop, drain (0x55 must never appear)
    add(1, 0, 8'h51, 0, 0, 8'h00, 0,  8'h00, 1, 8'h51, 8'h00, 1);
    add(1, 0, 8'h52, 0, 0, 8'h00, 0,  8'h00, 1, 8'h51, 8'h00, 1);
    add(1, 0, 8'h53, 0, 0, 8'h00, 0,  8'h00, 1, 8'h51, 8'h00, 1);
    add(1, 0, 8'h54, 0, 0, 8'h00, 0,  8'h02, 1, 8'h51, 8'h00, 1);
    add(1, 0, 8'h55, 0, 0, 8'h00, 0,  8'h0A, 1, 8'h51, 8'h00, 1);
    add(1, 1, 8'h04, 0, 0, 8'h00, 0,  8'h02, 1, 8'h51, 8'h00, 1);
    add(1, 0, 8'h56, 0, 1, 8'h00, 0,  8'h02, 1, 8'h52, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h00, 1, 8'h53, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h00, 1, 8'h54, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h00, 1, 8'h56, 8'h00, 1);
    add(0, 0, 8'h00, 0, 1, 8'h00, 0,  8'h04, 0, 8'h00, 8'h00, 1);
    // RX fill, full with same-edge read, drain, underflow, clear
    add(0, 0, 8'h00, 0, 0, 8'hA0, 1,  8'h25, 0, 8'h00, 8'hA0, 1);
    add(0, 0, 8'h00, 0, 0, 8'hA1, 1,  8'h45, 0, 8'h00, 8'hA0, 1);
    add(0, 0, 8'h00, 0, 0, 8'hA2, 1,  8'h65, 0, 8'h00, 8'hA0, 1);
    add(0, 0, 8'h00, 0, 0, 8'hA3, 1,  8'h85, 0, 8'h00, 8'hA0, 0);
    add(0, 0, 8'h00, 1, 0, 8'hA4, 1,  8'h65, 0, 8'h00, 8'hA1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  8'h45, 0, 8'h00, 8'hA2, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  8'h25, 0, 8'h00, 8'hA3, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  8'h04, 0, 8'h00, 8'h00, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 0,  8'h14, 0, 8'h00, 8'h00, 1);
    add(1, 1, 8'h08, 0, 0, 8'h00, 0,  8'h04, 0, 8'h00, 8'h00, 1);
    // Flush both while a byte is offered; ports 2/3 are inert
    add(0, 0, 8'h00, 0, 0, 8'hB0, 1,  8'h25, 0, 8'h00, 8'hB0, 1);
    add(0, 0, 8'h00, 0, 0, 8'hB1, 1,  8'h45, 0, 8'h00, 8'hB0, 1);
    add(1, 0, 8'h77, 0, 0, 8'h00, 0,  8'h41, 1, 8'h77, 8'hB0, 1);
    add(1, 2, 8'hFF, 0, 0, 8'h00, 0,  8'h41, 1, 8'h77, 8'hB0, 1);
    add(1, 3, 8'h03, 0, 0, 8'h00, 0,  8'h41, 1, 8'h77, 8'hB0, 1);
    add(1, 1, 8'h03, 0, 0, 8'hC0, 1,  8'h04, 0, 8'h00, 8'h00, 1);
    // RX flush with read-on-empty still flags underflow
    add(1, 1, 8'h02, 1, 0, 8'h00, 0,  8'h14, 0, 8'h00, 8'h00, 1);
    add(1, 1, 8'h08, 0, 0, 8'h00, 0,  8'h04, 0, 8'h00, 8'h00, 1);

    #1;
    chk("rst_status", 0, status, 8'h04);
    chk("rst_txv", 0, {7'b0, tx_valid}, 8'h00);
    chk("rst_txd", 0, tx_data, 8'h00);
    chk("rst_rdata", 0, rdata, 8'h00);
    chk("rst_rxr", 0, {7'b0, rx_ready}, 8'h01);

    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      we_out = vecs[i].we; port_sel = vecs[i].sel; wdata = vecs[i].wd;
      rd_en = vecs[i].rd; tx_ready = vecs[i].txr;
      rx_data = vecs[i].rxd; rx_valid = vecs[i].rxv;
      @(posedge clk);
      #1;
      $display("vec %0d: status=%02h txv=%0b txd=%02h rdata=%02h rxr=%0b",
               i, status, tx_valid, tx_data, rdata, rx_ready);
      chk("status", i, status, vecs[i].e_st);
      chk("tx_valid", i, {7'b0, tx_valid}, {7'b0, vecs[i].e_txv});
      chk("tx_data", i, tx_data, vecs[i].e_txd);
      chk("rdata", i, rdata, vecs[i].e_rdt);
      chk("rx_ready", i, {7'b0, rx_ready}, {7'b0, vecs[i].e_rxr});
    end

    // Fill both FIFOs, then drop reset between clock edges.
    @(negedge clk);
    idle();
    we_out = 1'b1; port_sel = 2'd0; wdata = 8'h99; rx_valid = 1'b1; rx_data = 8'hE0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("pre_arst_status", 0, status, 8'h83);
    chk("pre_arst_txv", 0, {7'b0, tx_valid}, 8'h01);
    chk("pre_arst_rxr", 0, {7'b0, rx_ready}, 8'h00);
    #1;
    reset = 1'b0;
    #1;
    $display("async reset: status=%02h txv=%0b txd=%02h rdata=%02h rxr=%0b",
             status, tx_valid, tx_data, rdata, rx_ready);
    chk("arst_status", 0, status, 8'h04);
    chk("arst_txv", 0, {7'b0, tx_valid}, 8'h00);
    chk("arst_txd", 0, tx_data, 8'h00);
    chk("arst_rdata", 0, rdata, 8'h00);
    chk("arst_rxr", 0, {7'b0, rx_ready}, 8'h01);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_arst_status", 0, status, 8'h04);
    chk("post_arst_txv", 0, {7'b0, tx_valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
